// File: rtl/uart_ram_loader.sv
// uart_ram_loader: 8N1 UART receiver that packs bytes little-endian into 32-bit
// words and writes them to consecutive RAM word addresses while holding the CPU
// in reset for the duration of a load session.
module uart_ram_loader #(
    parameter int unsigned ADDR_BITS    = 12,
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 uart_rx,
    input  logic                 load_en,
    output logic                 load_we,
    output logic [ADDR_BITS-3:0] load_addr,
    output logic [31:0]          load_data,
    output logic [3:0]           load_sel,
    output logic                 cpu_hold,
    output logic [ADDR_BITS-2:0] word_count,
    output logic                 frame_err,
    output logic                 wrapped
);

    localparam int unsigned WaW  = ADDR_BITS - 2;
    localparam int unsigned CntW = ADDR_BITS - 1;
    localparam int unsigned BitW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [BitW-1:0] BitFull = BitW'(CLKS_PER_BIT - 1);
    localparam logic [BitW-1:0] BitHalf = BitW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] CntMax  = {CntW{1'b1}};

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} rx_state_e;

    rx_state_e           state_q, state_d;
    logic                rx_meta_q, rx_sync_q;
    logic [BitW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [2:0]          bit_idx_q, bit_idx_d;
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic [7:0]          shift_q, shift_d;
    logic [31:0]         word_q, word_d;
    logic                load_en_q;
    logic                load_we_q, load_we_d;
    logic [WaW-1:0]      load_addr_q, load_addr_d;
    logic [31:0]         load_data_q, load_data_d;
    logic [3:0]          load_sel_q, load_sel_d;
    logic [CntW-1:0]     word_count_q, word_count_d;
    logic                frame_err_q, frame_err_d;
    logic                wrapped_q, wrapped_d;

    // Two-flop synchronizer for the asynchronous RX pin; idle level is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Next-state logic: RX bit timing, word assembly, write strobe and session control.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        bit_idx_d    = bit_idx_q;
        byte_idx_d   = byte_idx_q;
        shift_d      = shift_q;
        word_d       = word_q;
        load_we_d    = 1'b0;
        load_sel_d   = 4'b0000;
        load_addr_d  = load_addr_q;
        load_data_d  = load_data_q;
        word_count_d = word_count_q;
        frame_err_d  = frame_err_q;
        wrapped_d    = wrapped_q;

        // The write strobed last cycle is complete; advance to the next word.
        if (load_we_q) begin
            load_addr_d = load_addr_q + WaW'(1);
            if (&load_addr_q) begin
                wrapped_d = 1'b1;
            end
            if (word_count_q != CntMax) begin
                word_count_d = word_count_q + CntW'(1);
            end
        end

        // A new session starts with clean sticky flags.
        if (load_en && !load_en_q) begin
            frame_err_d = 1'b0;
            wrapped_d   = 1'b0;
        end

        if (!load_en) begin
            state_d      = StIdle;
            bit_cnt_d    = '0;
            bit_idx_d    = '0;
            byte_idx_d   = '0;
            load_addr_d  = '0;
            word_count_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!rx_sync_q) begin
                        state_d   = StStart;
                        bit_cnt_d = '0;
                    end
                end
                StStart: begin
                    if (bit_cnt_q == BitHalf) begin
                        bit_cnt_d = '0;
                        bit_idx_d = '0;
                        // A start bit gone high by mid-bit is a glitch, not a frame.
                        state_d   = rx_sync_q ? StIdle : StData;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BitW'(1);
                    end
                end
                StData: begin
                    if (bit_cnt_q == BitFull) begin
                        bit_cnt_d = '0;
                        shift_d   = {rx_sync_q, shift_q[7:1]};
                        if (bit_idx_q == 3'd7) begin
                            state_d = StStop;
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BitW'(1);
                    end
                end
                StStop: begin
                    if (bit_cnt_q == BitFull) begin
                        bit_cnt_d = '0;
                        state_d   = StIdle;
                        if (rx_sync_q) begin
                            if (byte_idx_q == 2'd3) begin
                                load_data_d = {shift_q, word_q[23:0]};
                                load_we_d   = 1'b1;
                                load_sel_d  = 4'b1111;
                                byte_idx_d  = '0;
                            end else begin
                                word_d[{byte_idx_q, 3'b000} +: 8] = shift_q;
                                byte_idx_d = byte_idx_q + 2'd1;
                            end
                        end else begin
                            // Bad stop bit: drop this byte and the partial word.
                            frame_err_d = 1'b1;
                            byte_idx_d  = '0;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BitW'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            bit_cnt_q    <= '0;
            bit_idx_q    <= '0;
            byte_idx_q   <= '0;
            shift_q      <= '0;
            word_q       <= '0;
            load_en_q    <= 1'b0;
            load_we_q    <= 1'b0;
            load_addr_q  <= '0;
            load_data_q  <= '0;
            load_sel_q   <= '0;
            word_count_q <= '0;
            frame_err_q  <= 1'b0;
            wrapped_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            bit_idx_q    <= bit_idx_d;
            byte_idx_q   <= byte_idx_d;
            shift_q      <= shift_d;
            word_q       <= word_d;
            load_en_q    <= load_en;
            load_we_q    <= load_we_d;
            load_addr_q  <= load_addr_d;
            load_data_q  <= load_data_d;
            load_sel_q   <= load_sel_d;
            word_count_q <= word_count_d;
            frame_err_q  <= frame_err_d;
            wrapped_q    <= wrapped_d;
        end
    end

    assign load_we    = load_we_q;
    assign load_addr  = load_addr_q;
    assign load_data  = load_data_q;
    assign load_sel   = load_sel_q;
    assign word_count = word_count_q;
    assign frame_err  = frame_err_q;
    assign wrapped    = wrapped_q;
    // CPU stays in reset through the write cycle even if load_en has just dropped.
    assign cpu_hold   = load_en | load_we_q;

endmodule

// File: tb/tb_uart_ram_loader.sv
// Directed bench for uart_ram_loader with CLKS_PER_BIT=4 and ADDR_BITS=4 (4 words).
module tb_uart_ram_loader;

    localparam int unsigned AB  = 4;
    localparam int unsigned CPB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          uart_rx = 1'b1;
    logic          load_en = 1'b0;
    logic          load_we;
    logic [AB-3:0] load_addr;
    logic [31:0]   load_data;
    logic [3:0]    load_sel;
    logic          cpu_hold;
    logic [AB-2:0] word_count;
    logic          frame_err;
    logic          wrapped;

    int n_assert = 0;
    int n_fail   = 0;

    // Write log filled by the monitor; the main block only reads it.
    int          nwr = 0;
    logic [31:0] wr_addr [32];
    logic [31:0] wr_data [32];
    logic [31:0] wr_sel  [32];
    logic        sel_bad  = 1'b0;
    logic        hold_bad = 1'b0;

    uart_ram_loader #(
        .ADDR_BITS   (AB),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .uart_rx   (uart_rx),
        .load_en   (load_en),
        .load_we   (load_we),
        .load_addr (load_addr),
        .load_data (load_data),
        .load_sel  (load_sel),
        .cpu_hold  (cpu_hold),
        .word_count(word_count),
        .frame_err (frame_err),
        .wrapped   (wrapped)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (load_we === 1'b1) begin
            if (nwr < 32) begin
                wr_addr[nwr] = 32'(load_addr);
                wr_data[nwr] = load_data;
                wr_sel[nwr]  = 32'(load_sel);
            end
            nwr = nwr + 1;
        end else if (load_sel !== 4'b0000) begin
            sel_bad = 1'b1;
        end
        if (load_en === 1'b1 && cpu_hold !== 1'b1) begin
            hold_bad = 1'b1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(CPB);
        end
        uart_rx = stop_bit;
        tick(CPB);
        uart_rx = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8], 1'b1);
        end
    endtask

    task automatic restart_session();
        load_en = 1'b0;
        tick(3);
        load_en = 1'b1;
        tick(2);
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_we"}, 32'(load_we), 32'd0);
        chk({pfx, "_addr"}, 32'(load_addr), 32'd0);
        chk({pfx, "_data"}, load_data, 32'd0);
        chk({pfx, "_sel"}, 32'(load_sel), 32'd0);
        chk({pfx, "_hold"}, 32'(cpu_hold), 32'd0);
        chk({pfx, "_wc"}, 32'(word_count), 32'd0);
        chk({pfx, "_ferr"}, 32'(frame_err), 32'd0);
        chk({pfx, "_wrap"}, 32'(wrapped), 32'd0);
    endtask

    initial begin
        int base;

        // Reset state.
        tick(3);
        rst = 1'b0;
        tick(1);
        chk_reset_outputs("rst0");

        // Single word 0x12345678.
        base = nwr;
        load_en = 1'b1;
        tick(2);
        send_word(32'h1234_5678);
        tick(8);
        chk("w1_count", 32'(nwr - base), 32'd1);
        chk("w1_data", wr_data[base], 32'h1234_5678);
        chk("w1_addr", wr_addr[base], 32'd0);
        chk("w1_sel", wr_sel[base], 32'hf);
        chk("w1_wc", 32'(word_count), 32'd1);
        chk("w1_addr_next", 32'(load_addr), 32'd1);
        chk("w1_hold", 32'(cpu_hold), 32'd1);

        // Dropping load_en clears address and count.
        load_en = 1'b0;
        tick(2);
        chk("off_addr", 32'(load_addr), 32'd0);
        chk("off_wc", 32'(word_count), 32'd0);
        chk("off_hold", 32'(cpu_hold), 32'd0);

        // Eight back-to-back bytes 0x01..0x08.
        base = nwr;
        load_en = 1'b1;
        tick(2);
        for (int i = 1; i <= 8; i++) begin
            send_byte(8'(i), 1'b1);
        end
        tick(8);
        chk("w8_count", 32'(nwr - base), 32'd2);
        chk("w8_data0", wr_data[base], 32'h0403_0201);
        chk("w8_addr0", wr_addr[base], 32'd0);
        chk("w8_data1", wr_data[base+1], 32'h0807_0605);
        chk("w8_addr1", wr_addr[base+1], 32'd1);
        chk("w8_wc", 32'(word_count), 32'd2);
        chk("hold_throughout", 32'(hold_bad), 32'd0);

        // Twenty bytes 0x00..0x13: five writes, the fifth wraps to word 0.
        restart_session();
        base = nwr;
        for (int i = 0; i < 20; i++) begin
            send_byte(8'(i), 1'b1);
        end
        tick(8);
        chk("w20_count", 32'(nwr - base), 32'd5);
        chk("w20_addr3", wr_addr[base+3], 32'd3);
        chk("w20_data4", wr_data[base+4], 32'h1312_1110);
        chk("w20_addr4", wr_addr[base+4], 32'd0);
        chk("w20_wrapped", 32'(wrapped), 32'd1);
        chk("w20_wc", 32'(word_count), 32'd5);
        chk("w20_addr_next", 32'(load_addr), 32'd1);

        // Rising load_en clears the sticky flags.
        restart_session();
        chk("sess_wrap_clr", 32'(wrapped), 32'd0);

        // Framing error drops the partial word.
        base = nwr;
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b0);
        tick(2 * CPB);
        chk("ferr_flag", 32'(frame_err), 32'd1);
        send_word(32'h4433_2211);
        tick(8);
        chk("ferr_count", 32'(nwr - base), 32'd1);
        chk("ferr_data", wr_data[base], 32'h4433_2211);
        chk("ferr_addr", wr_addr[base], 32'd0);
        chk("ferr_sticky", 32'(frame_err), 32'd1);

        // One-cycle glitch is ignored; a partial word is discarded when load_en drops.
        restart_session();
        chk("sess_ferr_clr", 32'(frame_err), 32'd0);
        base = nwr;
        uart_rx = 1'b0;
        tick(1);
        uart_rx = 1'b1;
        tick(3 * CPB);
        chk("glitch_ferr", 32'(frame_err), 32'd0);
        chk("glitch_nowr", 32'(nwr - base), 32'd0);
        send_byte(8'hC1, 1'b1);
        send_byte(8'hC2, 1'b1);
        tick(4);
        load_en = 1'b0;
        tick(4);
        chk("drop_nowr", 32'(nwr - base), 32'd0);
        chk("drop_addr", 32'(load_addr), 32'd0);
        chk("drop_wc", 32'(word_count), 32'd0);
        chk("drop_hold", 32'(cpu_hold), 32'd0);
        load_en = 1'b1;
        tick(2);
        send_word(32'hDDCC_BBAA);
        tick(8);
        chk("drop_next_data", wr_data[base], 32'hDDCC_BBAA);
        chk("drop_next_addr", wr_addr[base], 32'd0);

        // Reset in the middle of the third byte.
        restart_session();
        base = nwr;
        send_byte(8'h5A, 1'b1);
        send_byte(8'hA5, 1'b1);
        uart_rx = 1'b0;
        tick(CPB);
        uart_rx = 1'b1;
        tick(2 * CPB);
        rst = 1'b1;
        load_en = 1'b0;
        tick(1);
        chk_reset_outputs("midrst");
        rst = 1'b0;
        tick(2);
        chk("midrst_nowr", 32'(nwr - base), 32'd0);
        load_en = 1'b1;
        tick(2);
        send_word(32'hCAFE_F00D);
        tick(8);
        chk("postrst_count", 32'(nwr - base), 32'd1);
        chk("postrst_data", wr_data[base], 32'hCAFE_F00D);
        chk("postrst_addr", wr_addr[base], 32'd0);
        chk("postrst_wc", 32'(word_count), 32'd1);

        chk("sel_idle_zero", 32'(sel_bad), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
